// File: rtl/pll_ddr_ctrl_pkg.sv
// Shared types and widths for the DDR PLL sequencer.
// Holds the FSM state enum, the dynamic-adjust field width and the relock counter width.
package pll_ctrl_pkg;

    localparam int DA_W     = 4;
    localparam int RELOCK_W = 8;

    typedef enum logic [2:0] {
        RST_HOLD,
        WAIT_LOCK,
        READY,
        SETTLE,
        FAIL
    } pll_state_e;

    typedef struct packed {
        logic [DA_W-1:0] psda;
        logic [DA_W-1:0] dutyda;
        logic [DA_W-1:0] fdly;
    } pll_cfg_t;

endpackage

// File: rtl/pll_ddr_ctrl_lock_filter.sv
// Brings the asynchronous PLL lock into clk and debounces it.
// The filtered level flips only after LOCK_FILTER consecutive synced samples disagree with it.
module pll_lock_filter #(
    parameter int LOCK_FILTER = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pll_lock,
    output logic lock_filt
);

    localparam int CNT_W = $clog2(LOCK_FILTER) + 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any sample that agrees with the current level restarts the run count.
    always_comb begin
        sync1_d = pll_lock;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_W'(LOCK_FILTER - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign lock_filt = filt_q;

endmodule

// File: rtl/pll_ddr_ctrl.sv
// DDR PLL sequencer: reset/lock qualification with retry, lock-loss recovery,
// and serialised phase/duty/fine-delay updates with a settle window before ack.
module pll_ddr_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned     RST_CYCLES    = 16,
    parameter int unsigned     LOCK_TIMEOUT  = 65536,
    parameter int unsigned     LOCK_FILTER   = 4,
    parameter int unsigned     SETTLE_CYCLES = 32,
    parameter int unsigned     MAX_RETRY     = 4,
    parameter logic [DA_W-1:0] PSDA_INIT     = 4'b0000,
    parameter logic [DA_W-1:0] DUTYDA_INIT   = 4'b1000,
    parameter logic [DA_W-1:0] FDLY_INIT     = 4'b0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pll_lock,
    output logic                pll_reset,
    output logic [DA_W-1:0]     psda,
    output logic [DA_W-1:0]     dutyda,
    output logic [DA_W-1:0]     fdly,
    input  logic                cfg_req,
    input  logic [DA_W-1:0]     cfg_psda,
    input  logic [DA_W-1:0]     cfg_dutyda,
    input  logic [DA_W-1:0]     cfg_fdly,
    output logic                cfg_ack,
    output logic                ready,
    output logic                fail,
    output logic [RELOCK_W-1:0] relock_count
);

    localparam int RST_W = $clog2(RST_CYCLES) + 1;
    localparam int TO_W  = $clog2(LOCK_TIMEOUT) + 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
    localparam int RET_W = $clog2(MAX_RETRY) + 1;

    localparam pll_cfg_t CFG_INIT = '{psda: PSDA_INIT, dutyda: DUTYDA_INIT, fdly: FDLY_INIT};

    logic lock_filt;

    pll_state_e          state_q, state_d;
    logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [SET_W-1:0]    set_cnt_q, set_cnt_d;
    logic [RET_W-1:0]    retry_q, retry_d;
    logic [RELOCK_W-1:0] relock_q, relock_d;
    logic                ack_q, ack_d;
    pll_cfg_t            cfg_q, cfg_d;

    pll_lock_filter #(
        .LOCK_FILTER(LOCK_FILTER)
    ) u_lock_filter (
        .clk      (clk),
        .reset    (reset),
        .pll_lock (pll_lock),
        .lock_filt(lock_filt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RST_HOLD;
            rst_cnt_q <= '0;
            to_cnt_q  <= '0;
            set_cnt_q <= '0;
            retry_q   <= '0;
            relock_q  <= '0;
            ack_q     <= 1'b0;
            cfg_q     <= CFG_INIT;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            to_cnt_q  <= to_cnt_d;
            set_cnt_q <= set_cnt_d;
            retry_q   <= retry_d;
            relock_q  <= relock_d;
            ack_q     <= ack_d;
            cfg_q     <= cfg_d;
        end
    end

    // Counters default to zero so each one starts cleared on entry to its state.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = '0;
        to_cnt_d  = '0;
        set_cnt_d = '0;
        retry_d   = retry_q;
        relock_d  = relock_q;
        ack_d     = 1'b0;
        cfg_d     = cfg_q;
        case (state_q)
            RST_HOLD: begin
                if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_filt) begin
                    state_d = READY;
                    retry_d = '0;
                end else if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_q + RET_W'(1);
                    state_d = (retry_d == RET_W'(MAX_RETRY)) ? FAIL : RST_HOLD;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            READY: begin
                // Lock loss outranks a request; ack_q masks the requester's trailing cycle.
                if (!lock_filt) begin
                    state_d = RST_HOLD;
                    if (relock_q != '1) relock_d = relock_q + RELOCK_W'(1);
                end else if (cfg_req && !ack_q) begin
                    cfg_d   = '{psda: cfg_psda, dutyda: cfg_dutyda, fdly: cfg_fdly};
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!lock_filt) begin
                    state_d = RST_HOLD;
                    if (relock_q != '1) relock_d = relock_q + RELOCK_W'(1);
                end else if (set_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    ack_d   = 1'b1;
                    state_d = READY;
                end else begin
                    set_cnt_d = set_cnt_q + SET_W'(1);
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = RST_HOLD;
            end
        endcase
    end

    always_comb begin
        pll_reset = 1'b0;
        ready     = 1'b0;
        fail      = 1'b0;
        case (state_q)
            RST_HOLD: pll_reset = 1'b1;
            READY:    ready     = 1'b1;
            FAIL: begin
                pll_reset = 1'b1;
                fail      = 1'b1;
            end
            default: ;
        endcase
    end

    assign psda         = cfg_q.psda;
    assign dutyda       = cfg_q.dutyda;
    assign fdly         = cfg_q.fdly;
    assign cfg_ack      = ack_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_ddr_ctrl.sv
// Self-checking bench for pll_ddr_ctrl: latencies derived from the sequencing rules,
// plus a queue of expected configurations matched against every cfg_ack.
module tb_pll_ddr_ctrl;

    localparam int RST_CYCLES    = 16;
    localparam int LOCK_TIMEOUT  = 128;
    localparam int LOCK_FILTER   = 4;
    localparam int SETTLE_CYCLES = 32;
    localparam int MAX_RETRY     = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       pll_reset;
    logic [3:0] psda, dutyda, fdly;
    logic       cfg_req;
    logic [3:0] cfg_psda, cfg_dutyda, cfg_fdly;
    logic       cfg_ack;
    logic       ready;
    logic       fail;
    logic [7:0] relock_count;

    int          total = 0;
    int          bad = 0;
    int          ack_seen = 0;
    logic [11:0] exp_q[$];
    logic [11:0] exp_v;

    int          n, m, falls, a0, r0, g;
    logic        prev;
    logic [11:0] v;

    always #5 clk = ~clk;

    pll_ddr_ctrl #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .LOCK_FILTER  (LOCK_FILTER),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .MAX_RETRY    (MAX_RETRY),
        .PSDA_INIT    (4'b0000),
        .DUTYDA_INIT  (4'b1000),
        .FDLY_INIT    (4'b0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .psda        (psda),
        .dutyda      (dutyda),
        .fdly        (fdly),
        .cfg_req     (cfg_req),
        .cfg_psda    (cfg_psda),
        .cfg_dutyda  (cfg_dutyda),
        .cfg_fdly    (cfg_fdly),
        .cfg_ack     (cfg_ack),
        .ready       (ready),
        .fail        (fail),
        .relock_count(relock_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pll_reset"}, pll_reset, 1);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_fail"}, fail, 0);
        chk({tag, "_ack"}, cfg_ack, 0);
        chk({tag, "_relock"}, relock_count, 0);
        chk({tag, "_cfg"}, {psda, dutyda, fdly}, 12'h080);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!ready && k < 2000) begin
            step();
            k++;
        end
        chk("wait_ready", ready, 1);
    endtask

    // One complete request: accept, settle, single ack, requester drops one cycle late.
    task automatic do_req(input logic [3:0] p, input logic [3:0] d, input logic [3:0] f);
        int k, acks0;
        wait_ready();
        acks0 = ack_seen;
        cfg_psda = p;
        cfg_dutyda = d;
        cfg_fdly = f;
        cfg_req = 1'b1;
        exp_q.push_back({p, d, f});
        step();
        chk("req_outputs", {psda, dutyda, fdly}, {p, d, f});
        chk("req_ready_low", ready, 0);
        k = 1;
        while (!cfg_ack && k < 200) begin
            step();
            k++;
        end
        chk("ack_latency", k, SETTLE_CYCLES + 1);
        step();
        cfg_req = 1'b0;
        chk("ack_one_cycle", cfg_ack, 0);
        repeat (40) step();
        chk("no_second_ack", ack_seen, acks0 + 1);
        chk("ready_after_req", ready, 1);
        chk("cfg_after_req", {psda, dutyda, fdly}, {p, d, f});
    endtask

    always @(negedge clk) begin
        if (cfg_ack) begin
            ack_seen++;
            if (exp_q.size() == 0) begin
                chk("ack_unexpected", 1, 0);
            end else begin
                exp_v = exp_q.pop_front();
                chk("ack_cfg", {psda, dutyda, fdly}, exp_v);
            end
        end
    end

    initial begin
        reset = 1'b1;
        pll_lock = 1'b0;
        cfg_req = 1'b0;
        cfg_psda = 4'h0;
        cfg_dutyda = 4'h0;
        cfg_fdly = 4'h0;
        repeat (3) step();
        check_reset_vals("por");

        // Power-up: reset pulse length, then lock 100 cycles later.
        reset = 1'b0;
        n = 0;
        while (pll_reset && n < 1000) begin
            step();
            n++;
        end
        chk("rst_pulse_len", n, RST_CYCLES);
        repeat (100) step();
        chk("wait_lock_not_ready", ready, 0);
        chk("wait_lock_pll_reset", pll_reset, 0);
        pll_lock = 1'b1;
        n = 0;
        while (!ready && n < 500) begin
            step();
            n++;
        end
        chk("lock_to_ready", n, 2 + LOCK_FILTER + 1);
        chk("powerup_relock", relock_count, 0);

        // Directed and random updates.
        do_req(4'd5, 4'd8, 4'd3);
        repeat (4) do_req(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        // Lock loss during SETTLE: no ack, relock, request re-serviced.
        wait_ready();
        v = 12'($urandom_range(0, 4095));
        cfg_psda = v[11:8];
        cfg_dutyda = v[7:4];
        cfg_fdly = v[3:0];
        cfg_req = 1'b1;
        exp_q.push_back(v);
        a0 = ack_seen;
        step();
        chk("ll_req_outputs", {psda, dutyda, fdly}, v);
        repeat (5) step();
        pll_lock = 1'b0;
        n = 0;
        while (!pll_reset && n < 100) begin
            step();
            n++;
        end
        chk("lockloss_latency", n, 2 + LOCK_FILTER + 1);
        chk("lockloss_relock", relock_count, 1);
        m = 0;
        while (pll_reset && m < 1000) begin
            if (m == 3) pll_lock = 1'b1;
            step();
            m++;
        end
        chk("relock_pulse_len", m, RST_CYCLES);
        chk("cfg_kept", {psda, dutyda, fdly}, v);
        n = 0;
        while (!ready && n < 500) begin
            step();
            n++;
        end
        chk("relock_ready", n, 1);
        step();
        n = 1;
        while (!cfg_ack && n < 200) begin
            step();
            n++;
        end
        chk("reservice_ack_lat", n, SETTLE_CYCLES + 1);
        step();
        cfg_req = 1'b0;
        chk("lockloss_one_ack", ack_seen, a0 + 1);
        repeat (10) step();

        // Short lock glitches are filtered out.
        for (int i = 0; i < 3; i++) begin
            wait_ready();
            r0 = relock_count;
            g = $urandom_range(1, LOCK_FILTER - 1);
            pll_lock = 1'b0;
            repeat (g) step();
            pll_lock = 1'b1;
            repeat (20) step();
            chk("glitch_relock", relock_count, r0);
            chk("glitch_ready", ready, 1);
            chk("glitch_pll_reset", pll_reset, 0);
        end

        // Reset in the middle of SETTLE aborts the pending ack.
        wait_ready();
        v = 12'($urandom_range(0, 4095));
        cfg_psda = v[11:8];
        cfg_dutyda = v[7:4];
        cfg_fdly = v[3:0];
        cfg_req = 1'b1;
        exp_q.push_back(v);
        step();
        repeat ($urandom_range(2, 20)) step();
        a0 = ack_seen;
        reset = 1'b1;
        cfg_req = 1'b0;
        step();
        check_reset_vals("mid_settle_reset");
        exp_q.delete();
        reset = 1'b0;
        repeat (50) step();
        chk("abort_no_ack", ack_seen, a0);
        chk("abort_ready_again", ready, 1);
        chk("abort_cfg_init", {psda, dutyda, fdly}, 12'h080);

        // Lock never arrives: MAX_RETRY pulses, then sticky FAIL.
        reset = 1'b1;
        pll_lock = 1'b0;
        step();
        step();
        reset = 1'b0;
        n = 0;
        falls = 0;
        prev = pll_reset;
        while (!fail && n < 3000) begin
            step();
            n++;
            if (prev && !pll_reset) falls++;
            prev = pll_reset;
        end
        chk("fail_latency", n, MAX_RETRY * (RST_CYCLES + LOCK_TIMEOUT));
        chk("fail_pulses", falls, MAX_RETRY);
        chk("fail_pll_reset", pll_reset, 1);
        chk("fail_ready", ready, 0);
        a0 = ack_seen;
        cfg_psda = 4'hA;
        cfg_dutyda = 4'h3;
        cfg_fdly = 4'h7;
        cfg_req = 1'b1;
        repeat (30) step();
        pll_lock = 1'b1;
        repeat (30) step();
        chk("fail_sticky", fail, 1);
        chk("fail_sticky_reset", pll_reset, 1);
        chk("fail_ignores_req", ack_seen, a0);
        chk("fail_cfg_init", {psda, dutyda, fdly}, 12'h080);
        reset = 1'b1;
        cfg_req = 1'b0;
        step();
        chk("fail_cleared", fail, 0);
        reset = 1'b0;
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
